// File: rtl/clkwiz_seq_pkg.sv
// Shared types and helpers for the ClkWiz control sequencer.
package clkwiz_seq_pkg;

    localparam int COUNT_W = 24;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HOLD      = 3'd1,
        WAIT_LOCK = 3'd2,
        MEASURE   = 3'd3,
        CAPTURE   = 3'd4,
        FINISH    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ST_OK           = 2'd0,
        ST_LOCK_TIMEOUT = 2'd1,
        ST_FREQ_ERR     = 2'd2,
        ST_LOCK_LOST    = 2'd3
    } status_e;

    // |a - b| through a 25-bit signed difference, so neither direction wraps.
    function automatic logic [COUNT_W-1:0] abs_diff(input logic [COUNT_W-1:0] a,
                                                    input logic [COUNT_W-1:0] b);
        logic signed [COUNT_W:0] d;
        logic signed [COUNT_W:0] nd;
        d  = $signed({1'b0, a}) - $signed({1'b0, b});
        nd = -d;
        return d[COUNT_W] ? nd[COUNT_W-1:0] : d[COUNT_W-1:0];
    endfunction

    function automatic logic param_ok(input int v);
        return (v > 32'sd0) && (v < (32'sd1 <<< COUNT_W));
    endfunction

endpackage

// File: rtl/clkwiz_seq_timer.sv
// Loadable down-counter with zero flag, shared by every timed sequencer state.
module seq_timer
    import clkwiz_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_val,
    output logic               zero
);

    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_d;

    // Next count: reload wins, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {COUNT_W{1'b0}}) begin
            cnt_d = cnt_q - {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {COUNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {COUNT_W{1'b0}});

endmodule

// File: rtl/clkwiz_seq.sv
// Start-to-done sequencer for the ClkWiz control block: source switch, MMCM reset,
// lock wait, frequency check. Optional idle lock monitor: CLKWIZ_SEQ_LOCK_MON_EN.
module clkwiz_seq
    import clkwiz_seq_pkg::*;
#(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int MEAS_CYCLES  = 1000000,
    parameter int CAPTURE_DLY  = 8,
    parameter int FREQ_TOL     = 16
)
(
    input  logic               pl_clk0,
    input  logic               pl_reset_n,
    input  logic               start,
    input  logic               src_sel_req,
    input  logic [COUNT_W-1:0] expect_count,
    input  logic               clk_locked,
    input  logic [COUNT_W-1:0] fmeas_count,
    output logic               clk_reset,
    output logic               sys_reset,
    output logic               clkin_src_sel,
    output logic               fmeas_enable,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status,
    output logic [COUNT_W-1:0] meas_count
);

    if (!param_ok(RST_HOLD) || !param_ok(LOCK_TIMEOUT) || !param_ok(MEAS_CYCLES) ||
        !param_ok(CAPTURE_DLY) || !param_ok(FREQ_TOL)) begin : g_bad_param
        $error("clkwiz_seq: every timing parameter must be nonzero and below 2**24");
    end

    // Timer reload values are one less than the state length: zero marks the last cycle.
    localparam logic [COUNT_W-1:0] HOLD_LD = COUNT_W'(RST_HOLD - 1);
    localparam logic [COUNT_W-1:0] LOCK_LD = COUNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [COUNT_W-1:0] MEAS_LD = COUNT_W'(MEAS_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CAP_LD  = COUNT_W'(CAPTURE_DLY - 1);
    localparam logic [COUNT_W-1:0] TOL_C   = COUNT_W'(FREQ_TOL);

    state_e             state_q,      state_d;
    status_e            status_q,     status_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;
    logic               clk_reset_q,  clk_reset_d;
    logic               sys_reset_q,  sys_reset_d;
    logic               src_sel_q,    src_sel_d;
    logic               fmeas_en_q,   fmeas_en_d;
    logic [COUNT_W-1:0] meas_count_q, meas_count_d;
    logic [COUNT_W-1:0] expect_q,     expect_d;
    logic [COUNT_W-1:0] diff_q,       diff_d;
    logic [1:0]         cap_phase_q,  cap_phase_d;
`ifdef CLKWIZ_SEQ_LOCK_MON_EN
    logic               armed_q,      armed_d;
`endif

    logic               accept_s;
    logic               finish_s;
    status_e            fin_st_s;
    logic               tmr_load_s;
    logic [COUNT_W-1:0] tmr_val_s;
    logic               tmr_zero_s;

    seq_timer u_timer (
        .clk      (pl_clk0),
        .rst_n    (pl_reset_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Next-state and next-output logic for the whole sequence.
    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        clk_reset_d  = clk_reset_q;
        sys_reset_d  = sys_reset_q;
        src_sel_d    = src_sel_q;
        fmeas_en_d   = fmeas_en_q;
        meas_count_d = meas_count_q;
        expect_d     = expect_q;
        diff_d       = diff_q;
        cap_phase_d  = cap_phase_q;
`ifdef CLKWIZ_SEQ_LOCK_MON_EN
        armed_d      = armed_q;
`endif
        finish_s     = 1'b0;
        fin_st_s     = ST_OK;
        tmr_load_s   = 1'b0;
        tmr_val_s    = {COUNT_W{1'b0}};

        // FINISH already has busy low, so a start there is taken like one in IDLE.
        accept_s = start && ((state_q == IDLE) || (state_q == FINISH));

        if (accept_s) begin
            state_d     = HOLD;
            busy_d      = 1'b1;
            src_sel_d   = src_sel_req;
            expect_d    = expect_count;
            clk_reset_d = 1'b1;
            sys_reset_d = 1'b1;
            fmeas_en_d  = 1'b0;
            tmr_load_s  = 1'b1;
            tmr_val_s   = HOLD_LD;
`ifdef CLKWIZ_SEQ_LOCK_MON_EN
            armed_d     = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef CLKWIZ_SEQ_LOCK_MON_EN
                    if (armed_q && !clk_locked) begin
                        finish_s = 1'b1;
                        fin_st_s = ST_LOCK_LOST;
                    end else begin
                        finish_s = 1'b0;
                    end
`else
                    finish_s = 1'b0;
`endif
                end
                HOLD: begin
                    if (tmr_zero_s) begin
                        state_d     = WAIT_LOCK;
                        clk_reset_d = 1'b0;
                        tmr_load_s  = 1'b1;
                        tmr_val_s   = LOCK_LD;
                    end else begin
                        state_d = HOLD;
                    end
                end
                WAIT_LOCK: begin
                    if (clk_locked) begin
                        state_d     = MEASURE;
                        sys_reset_d = 1'b0;
                        fmeas_en_d  = 1'b1;
                        tmr_load_s  = 1'b1;
                        tmr_val_s   = MEAS_LD;
                    end else if (tmr_zero_s) begin
                        finish_s = 1'b1;
                        fin_st_s = ST_LOCK_TIMEOUT;
                    end else begin
                        state_d = WAIT_LOCK;
                    end
                end
                MEASURE: begin
                    if (!clk_locked) begin
                        finish_s = 1'b1;
                        fin_st_s = ST_LOCK_LOST;
                    end else if (tmr_zero_s) begin
                        state_d     = CAPTURE;
                        fmeas_en_d  = 1'b0;
                        cap_phase_d = 2'd0;
                        tmr_load_s  = 1'b1;
                        tmr_val_s   = CAP_LD;
                    end else begin
                        state_d = MEASURE;
                    end
                end
                CAPTURE: begin
                    // Phases: wait for the count CDC, register |diff|, then judge it.
                    if (!clk_locked) begin
                        finish_s = 1'b1;
                        fin_st_s = ST_LOCK_LOST;
                    end else begin
                        case (cap_phase_q)
                            2'd0: begin
                                if (tmr_zero_s) begin
                                    meas_count_d = fmeas_count;
                                    cap_phase_d  = 2'd1;
                                end else begin
                                    cap_phase_d = 2'd0;
                                end
                            end
                            2'd1: begin
                                diff_d      = abs_diff(meas_count_q, expect_q);
                                cap_phase_d = 2'd2;
                            end
                            2'd2: begin
                                finish_s = 1'b1;
                                fin_st_s = (diff_q <= TOL_C) ? ST_OK : ST_FREQ_ERR;
                            end
                            default: begin
                                cap_phase_d = 2'd0;
                            end
                        endcase
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (finish_s) begin
                state_d     = FINISH;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                status_d    = fin_st_s;
                fmeas_en_d  = 1'b0;
                clk_reset_d = 1'b0;
                sys_reset_d = (fin_st_s == ST_OK) ? sys_reset_q : 1'b1;
`ifdef CLKWIZ_SEQ_LOCK_MON_EN
                armed_d     = (fin_st_s == ST_OK);
`endif
            end else begin
                done_d = 1'b0;
            end
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge pl_clk0 or negedge pl_reset_n) begin
        if (!pl_reset_n) begin
            state_q      <= IDLE;
            status_q     <= ST_OK;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            clk_reset_q  <= 1'b0;
            sys_reset_q  <= 1'b1;
            src_sel_q    <= 1'b0;
            fmeas_en_q   <= 1'b0;
            meas_count_q <= {COUNT_W{1'b0}};
            expect_q     <= {COUNT_W{1'b0}};
            diff_q       <= {COUNT_W{1'b0}};
            cap_phase_q  <= 2'd0;
`ifdef CLKWIZ_SEQ_LOCK_MON_EN
            armed_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            clk_reset_q  <= clk_reset_d;
            sys_reset_q  <= sys_reset_d;
            src_sel_q    <= src_sel_d;
            fmeas_en_q   <= fmeas_en_d;
            meas_count_q <= meas_count_d;
            expect_q     <= expect_d;
            diff_q       <= diff_d;
            cap_phase_q  <= cap_phase_d;
`ifdef CLKWIZ_SEQ_LOCK_MON_EN
            armed_q      <= armed_d;
`endif
        end
    end

    assign clk_reset     = clk_reset_q;
    assign sys_reset     = sys_reset_q;
    assign clkin_src_sel = src_sel_q;
    assign fmeas_enable  = fmeas_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign status        = status_q;
    assign meas_count    = meas_count_q;

endmodule

// File: tb/tb_clkwiz_seq.sv
// Directed, scoreboard-checked bench for clkwiz_seq (honours CLKWIZ_SEQ_LOCK_MON_EN).
module tb_clkwiz_seq;

    localparam int RH  = 4;
    localparam int LT  = 100;
    localparam int MC  = 50;
    localparam int CD  = 8;
    localparam int TOL = 2;
    localparam int L   = 10;

    typedef struct {
        int          cyc;
        logic [1:0]  st;
        logic [23:0] mc;
        logic        sr;
    } exp_t;

    exp_t sb_q[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        src_sel_req;
    logic [23:0] expect_count;
    logic        clk_locked;
    logic [23:0] fmeas_count;
    logic        clk_reset;
    logic        sys_reset;
    logic        clkin_src_sel;
    logic        fmeas_enable;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [23:0] meas_count;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          clkr_cnt = 0;
    int          fm_cnt = 0;
    int          done_cnt = 0;
    int          sysr_fall_cyc = 0;
    int          fm_rise_cyc = 0;
    logic        prev_sys = 1'b1;
    logic        prev_fm = 1'b0;
    logic [23:0] last_meas = 24'd0;

    clkwiz_seq #(
        .RST_HOLD     (RH),
        .LOCK_TIMEOUT (LT),
        .MEAS_CYCLES  (MC),
        .CAPTURE_DLY  (CD),
        .FREQ_TOL     (TOL)
    ) dut (
        .pl_clk0       (clk),
        .pl_reset_n    (rst_n),
        .start         (start),
        .src_sel_req   (src_sel_req),
        .expect_count  (expect_count),
        .clk_locked    (clk_locked),
        .fmeas_count   (fmeas_count),
        .clk_reset     (clk_reset),
        .sys_reset     (sys_reset),
        .clkin_src_sel (clkin_src_sel),
        .fmeas_enable  (fmeas_enable),
        .busy          (busy),
        .done          (done),
        .status        (status),
        .meas_count    (meas_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output activity counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (clk_reset) clkr_cnt <= clkr_cnt + 1;
        if (fmeas_enable) fm_cnt <= fm_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (prev_sys && !sys_reset) sysr_fall_cyc <= cyc;
        if (!prev_fm && fmeas_enable) fm_rise_cyc <= cyc;
        prev_sys <= sys_reset;
        prev_fm  <= fmeas_enable;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_clk_reset"}, 32'(clk_reset), 32'd0);
        check({tag, "_sys_reset"}, 32'(sys_reset), 32'd1);
        check({tag, "_src_sel"},   32'(clkin_src_sel), 32'd0);
        check({tag, "_fmeas_en"},  32'(fmeas_enable), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_done"},      32'(done), 32'd0);
        check({tag, "_status"},    32'(status), 32'd0);
        check({tag, "_meas"},      32'(meas_count), 32'd0);
    endtask

    task automatic expect_done(input int c, input logic [1:0] st, input logic [23:0] mc,
                               input logic sr);
        exp_t e;
        e.cyc = c;
        e.st  = st;
        e.mc  = mc;
        e.sr  = sr;
        sb_q.push_back(e);
    endtask

    // Called on a falling edge; start is seen by the DUT on the next rising edge.
    task automatic pulse_start(input logic sel, input logic [23:0] ec, output int s);
        start        = 1'b1;
        src_sel_req  = sel;
        expect_count = ec;
        s            = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_cycle"},     32'(cyc), 32'(e.cyc));
            check({tag, "_status"},    32'(status), 32'(e.st));
            check({tag, "_meas"},      32'(meas_count), 32'(e.mc));
            check({tag, "_sys_reset"}, 32'(sys_reset), 32'(e.sr));
        end else begin
            check({tag, "_scoreboard"}, 32'(sb_q.size()), 32'd1);
        end
    endtask

    // Full sequence with lock arriving L cycles after HOLD ends.
    task automatic run_locked(input string tag, input logic sel, input logic [23:0] ec,
                              input logic [23:0] fc, input logic [1:0] st);
        int s;
        int cr0;
        int fm0;
        fmeas_count = fc;
        cr0 = clkr_cnt;
        fm0 = fm_cnt;
        pulse_start(sel, ec, s);
        expect_done(s + 1 + RH + L + MC + CD + 2, st, fc, (st != 2'd0));
        check({tag, "_src_sel"}, 32'(clkin_src_sel), 32'(sel));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        repeat (RH + L - 1) @(negedge clk);
        clk_locked = 1'b1;
        wait_done(tag, 300);
        last_meas = fc;
        check({tag, "_clk_reset_len"}, 32'(clkr_cnt - cr0), 32'(RH));
        check({tag, "_fmeas_len"}, 32'(fm_cnt - fm0), 32'(MC));
        check({tag, "_fmeas_rise"}, 32'(fm_rise_cyc), 32'(s + 1 + RH + L));
        check({tag, "_sys_fall"}, 32'(sysr_fall_cyc), 32'(s + 1 + RH + L));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    // Lock drops while idle after a successful sequence.
    task automatic drop_lock_idle(input string tag);
        int dn0;
        dn0 = done_cnt;
        clk_locked = 1'b0;
`ifdef CLKWIZ_SEQ_LOCK_MON_EN
        expect_done(cyc + 1, 2'd3, last_meas, 1'b1);
        wait_done(tag, 5);
        repeat (3) @(negedge clk);
        check({tag, "_one_done"}, 32'(done_cnt - dn0), 32'd1);
`else
        repeat (3) @(negedge clk);
        check({tag, "_no_done"}, 32'(done_cnt - dn0), 32'd0);
        check({tag, "_status"}, 32'(status), 32'd0);
        check({tag, "_sys_reset"}, 32'(sys_reset), 32'd0);
`endif
    endtask

    initial begin
        int s;
        int fm0;
        int dn0;
        rst_n        = 1'b0;
        start        = 1'b0;
        src_sel_req  = 1'b0;
        expect_count = 24'd0;
        clk_locked   = 1'b0;
        fmeas_count  = 24'd0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_locked("nominal", 1'b1, 24'd50, 24'd51, 2'd0);
        drop_lock_idle("idle_drop1");

        // Lock never arrives.
        fm0 = fm_cnt;
        fmeas_count = 24'd51;
        pulse_start(1'b0, 24'd50, s);
        expect_done(s + 1 + RH + LT, 2'd1, last_meas, 1'b1);
        wait_done("timeout", 300);
        check("timeout_fmeas_len", 32'(fm_cnt - fm0), 32'd0);
        check("timeout_src_sel", 32'(clkin_src_sel), 32'd0);
        repeat (2) @(negedge clk);

        run_locked("freq_hi", 1'b1, 24'd50, 24'd60, 2'd2);
        clk_locked = 1'b0;
        repeat (2) @(negedge clk);
        run_locked("freq_lo", 1'b0, 24'd50, 24'd40, 2'd2);
        clk_locked = 1'b0;
        repeat (2) @(negedge clk);
        run_locked("tol_edge", 1'b1, 24'd50, 24'd52, 2'd0);
        drop_lock_idle("idle_drop2");
        run_locked("tol_edge_lo", 1'b1, 24'd50, 24'd48, 2'd0);
        drop_lock_idle("idle_drop3");

        // Lock lost at MEASURE cycle 20, with a start pulse dropped mid-sequence.
        fm0 = fm_cnt;
        dn0 = done_cnt;
        fmeas_count = 24'd51;
        pulse_start(1'b1, 24'd50, s);
        expect_done(s + 1 + RH + L + 20, 2'd3, last_meas, 1'b1);
        repeat (RH + L - 1) @(negedge clk);
        clk_locked = 1'b1;
        repeat (10) @(negedge clk);
        start       = 1'b1;
        src_sel_req = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        clk_locked = 1'b0;
        wait_done("lock_lost", 50);
        check("lock_lost_fmeas_off", 32'(fmeas_enable), 32'd0);
        check("lock_lost_fmeas_len", 32'(fm_cnt - fm0), 32'd20);
        check("lock_lost_src_kept", 32'(clkin_src_sel), 32'd1);
        repeat (4) @(negedge clk);
        check("lock_lost_one_done", 32'(done_cnt - dn0), 32'd1);
        check("lock_lost_busy", 32'(busy), 32'd0);

        // Asynchronous reset while waiting for lock.
        pulse_start(1'b1, 24'd50, s);
        repeat (RH + 3) @(negedge clk);
        check("async_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        rst_n = 1'b1;
        last_meas = 24'd0;
        repeat (2) @(negedge clk);

        run_locked("post_reset", 1'b1, 24'd50, 24'd51, 2'd0);
        drop_lock_idle("idle_drop4");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
